// File: rtl/dmem_mmio.sv
// dmem_mmio: word-addressed data RAM plus an MMIO window (LEDs, timer/compare irq, UART TX).
// Build with DMEM_MMIO_UART_EN defined to include the UART transmitter; otherwise uart_tx idles high.
module dmem_mmio #(
    parameter int unsigned RAM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int unsigned BAUD_DIV  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [7:0]  leds,
    output logic        irq_timer,
    output logic        uart_tx
);
    localparam int unsigned IdxW     = $clog2(RAM_WORDS);
    localparam logic [31:0] RamBytes = 32'(RAM_WORDS * 4);
    localparam logic [5:0]  OffLed     = 6'h00;
    localparam logic [5:0]  OffCount   = 6'h01;
    localparam logic [5:0]  OffCompare = 6'h02;
    localparam logic [5:0]  OffStatus  = 6'h03;
    localparam logic [5:0]  OffTxStat  = 6'h05;

    if (RAM_WORDS < 4 || (RAM_WORDS & (RAM_WORDS - 1)) != 0) begin : gBadRamWords
        $error("RAM_WORDS must be a power of two and at least 4");
    end
    if (BAUD_DIV < 2) begin : gBadBaudDiv
        $error("BAUD_DIV must be at least 2");
    end

    logic [31:0]     ram [RAM_WORDS];
    logic [31:0]     count;
    logic [31:0]     compare;
    logic            matchFlag;
    logic            matchSet;
    logic            clrMatch;
    logic            uartBusy;
    logic            isRam;
    logic            isMmio;
    logic            wrMmio;
    logic [IdxW-1:0] ramIdx;
    logic [5:0]      mmioOff;

    // Address decode; the low two address bits never matter.
    assign isRam   = a < RamBytes;
    assign isMmio  = a[31:8] == MMIO_BASE[31:8];
    assign ramIdx  = a[IdxW+1:2];
    assign mmioOff = a[7:2];
    assign wrMmio  = we && isMmio;

    always_ff @(posedge clk) begin : ramWrite
        if (we && isRam) begin
            ram[ramIdx] <= wd;
        end
    end

    // Match is sampled on the pre-edge count, so a same-cycle W1C loses to a new match.
    assign matchSet = (count == compare) && (compare != 32'h0);
    assign clrMatch = wrMmio && (mmioOff == OffStatus) && wd[0];

    always_ff @(posedge clk or negedge reset) begin : mmioRegs
        if (!reset) begin
            leds      <= 8'h00;
            count     <= 32'h0;
            compare   <= 32'h0;
            matchFlag <= 1'b0;
        end else begin
            count     <= (wrMmio && mmioOff == OffCount) ? 32'h0 : count + 32'd1;
            matchFlag <= matchSet | (matchFlag & ~clrMatch);
            if (wrMmio && mmioOff == OffCompare) begin
                compare <= wd;
            end
            if (wrMmio && mmioOff == OffLed) begin
                leds <= wd[7:0];
            end
        end
    end

    assign irq_timer = matchFlag;

`ifdef DMEM_MMIO_UART_EN
    typedef enum logic [1:0] {Idle, Start, Data, Stop} uartState_t;
    localparam int unsigned    BaudW     = $clog2(BAUD_DIV);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
    localparam logic [5:0]     OffTxData = 6'h04;

    uartState_t       state;
    uartState_t       nextState;
    logic [7:0]       shiftReg;
    logic [7:0]       nextShift;
    logic [BaudW-1:0] baudCnt;
    logic [BaudW-1:0] nextBaud;
    logic [2:0]       bitIdx;
    logic [2:0]       nextBitIdx;
    logic             txReg;
    logic             nextTx;
    logic             bitDone;

    assign bitDone = baudCnt == BaudLast;

    always_ff @(posedge clk or negedge reset) begin : uartRegs
        if (!reset) begin
            state    <= Idle;
            shiftReg <= 8'h00;
            baudCnt  <= '0;
            bitIdx   <= 3'd0;
            txReg    <= 1'b1;
        end else begin
            state    <= nextState;
            shiftReg <= nextShift;
            baudCnt  <= nextBaud;
            bitIdx   <= nextBitIdx;
            txReg    <= nextTx;
        end
    end

    // Frame sequencing; tx is registered from the next state so it lines up with the state.
    always_comb begin : uartNext
        nextState  = state;
        nextShift  = shiftReg;
        nextBaud   = baudCnt;
        nextBitIdx = bitIdx;
        nextTx     = 1'b1;
        if (state != Idle) begin
            nextBaud = bitDone ? '0 : baudCnt + BaudW'(1);
        end
        case (state)
            Idle: begin
                if (wrMmio && mmioOff == OffTxData) begin
                    nextState = Start;
                    nextShift = wd[7:0];
                    nextBaud  = '0;
                end
            end
            Start: begin
                if (bitDone) begin
                    nextState  = Data;
                    nextBitIdx = 3'd0;
                end
            end
            Data: begin
                if (bitDone) begin
                    nextShift  = {1'b0, shiftReg[7:1]};
                    nextBitIdx = bitIdx + 3'd1;
                    if (bitIdx == 3'd7) begin
                        nextState = Stop;
                    end
                end
            end
            Stop: begin
                if (bitDone) begin
                    nextState = Idle;
                end
            end
            default: nextState = Idle;
        endcase
        case (nextState)
            Start:   nextTx = 1'b0;
            Data:    nextTx = nextShift[0];
            default: nextTx = 1'b1;
        endcase
    end

    assign uartBusy = state != Idle;
    assign uart_tx  = txReg;
`else
    assign uartBusy = 1'b0;
    assign uart_tx  = 1'b1;
`endif

    // Zero-latency read mux; shows pre-edge state for same-cycle writes.
    always_comb begin : readMux
        rd = 32'h0;
        if (isRam) begin
            rd = ram[ramIdx];
        end else if (isMmio) begin
            case (mmioOff)
                OffLed:     rd = {24'h0, leds};
                OffCount:   rd = count;
                OffCompare: rd = compare;
                OffStatus:  rd = {30'h0, uartBusy, matchFlag};
                OffTxStat:  rd = {31'h0, uartBusy};
                default:    rd = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// Testbench for dmem_mmio: directed steps plus random traffic against a behavioural model.
module tb_dmem_mmio;
    localparam int          RamWords    = 64;
    localparam logic [31:0] Base        = 32'hFFFF_0000;
    localparam int          Baud        = 4;
    localparam int          FrameCycles = 10 * Baud;
`ifdef DMEM_MMIO_UART_EN
    localparam bit UartOn = 1'b1;
`else
    localparam bit UartOn = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] a     = 32'h0;
    logic [31:0] wd    = 32'h0;
    logic [31:0] rd;
    logic [7:0]  leds;
    logic        irq_timer;
    logic        uart_tx;

    int nAsserts = 0;
    int nFails   = 0;

    // Behavioural model state
    logic [31:0] ramM [RamWords];
    bit          ramV [RamWords];
    logic [7:0]  ledsM  = 8'h0;
    logic [31:0] cntM   = 32'h0;
    logic [31:0] cmpM   = 32'h0;
    bit          flagM  = 1'b0;
    int          cyc    = 0;
    bit          uAct   = 1'b0;
    int          uStart = 0;
    logic [9:0]  frameM = 10'h3FF;

    dmem_mmio #(.RAM_WORDS(RamWords), .MMIO_BASE(Base), .BAUD_DIV(Baud)) dut (
        .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd),
        .leds(leds), .irq_timer(irq_timer), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected end within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit busyM();
        return UartOn && uAct && (cyc - uStart) < FrameCycles;
    endfunction

    function automatic logic txM();
        if (!busyM()) return 1'b1;
        return frameM[4'((cyc - uStart) / Baud)];
    endfunction

    function automatic logic [31:0] expRd(input logic [31:0] addr, output bit known);
        known = 1'b1;
        if (addr < 32'(RamWords * 4)) begin
            known = ramV[addr[7:2]];
            return ramM[addr[7:2]];
        end
        if (addr[31:8] != Base[31:8]) return 32'h0;
        case (addr[7:2])
            6'd0:    return {24'h0, ledsM};
            6'd1:    return cntM;
            6'd2:    return cmpM;
            6'd3:    return {30'h0, busyM(), flagM};
            6'd5:    return {31'h0, busyM()};
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelReset();
        ledsM = 8'h0;
        cntM  = 32'h0;
        cmpM  = 32'h0;
        flagM = 1'b0;
        uAct  = 1'b0;
    endtask

    task automatic modelEdge(input logic w, input logic [31:0] ad, input logic [31:0] d);
        bit         isM;
        bit         busyB;
        bit         match;
        logic [5:0] off;
        isM   = ad[31:8] == Base[31:8];
        off   = ad[7:2];
        busyB = busyM();
        match = (cntM == cmpM) && (cmpM != 32'h0);
        flagM = match || (flagM && !(w && isM && off == 6'd3 && d[0]));
        cntM  = (w && isM && off == 6'd1) ? 32'h0 : cntM + 32'h1;
        cyc++;
        if (w) begin
            if (ad < 32'(RamWords * 4)) begin
                ramM[ad[7:2]] = d;
                ramV[ad[7:2]] = 1'b1;
            end else if (isM) begin
                if (off == 6'd0) ledsM = d[7:0];
                if (off == 6'd2) cmpM = d;
                if (off == 6'd4 && UartOn && !busyB) begin
                    uAct   = 1'b1;
                    uStart = cyc;
                    frameM = {1'b1, d[7:0], 1'b0};
                end
            end
        end
    endtask

    // One clock cycle: drive, check all outputs against the model, clock, advance model.
    task automatic step(input logic w, input logic [31:0] ad, input logic [31:0] d);
        logic [31:0] e;
        bit          known;
        we = w;
        a  = ad;
        wd = d;
        #1;
        e = expRd(ad, known);
        if (known) chk($sformatf("rd@%08h", ad), rd, e);
        chk("leds", 32'(leds), 32'(ledsM));
        chk("irq_timer", 32'(irq_timer), 32'(flagM));
        chk("uart_tx", 32'(uart_tx), 32'(txM()));
        @(posedge clk);
        modelEdge(w, ad, d);
        #1;
    endtask

    task automatic peek(input logic [31:0] ad, output logic [31:0] v);
        we = 1'b0;
        a  = ad;
        #1;
        v = rd;
    endtask

    task automatic asyncReset();
        logic [31:0] v;
        we = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        modelReset();
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_irq", 32'(irq_timer), 32'h0);
        chk("rst_uart_tx", 32'(uart_tx), 32'h1);
        peek(Base + 32'h14, v);
        chk("rst_busy", v, 32'h0);
        peek(Base + 32'h04, v);
        chk("rst_count", v, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin : main
        logic [31:0] v;
        int          nBusy;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_leds", 32'(leds), 32'h0);
        chk("reset_irq", 32'(irq_timer), 32'h0);
        chk("reset_uart_tx", 32'(uart_tx), 32'h1);
        peek(Base + 32'h08, v);
        chk("reset_compare", v, 32'h0);
        reset = 1'b1;

        // RAM write/read, ignored low bits, end of RAM
        step(1'b1, 32'h08, 32'hDEAD_BEEF);
        step(1'b0, 32'h08, 32'h0);
        peek(32'h0A, v);
        chk("ram_lowbits", v, 32'hDEAD_BEEF);
        step(1'b1, 32'h00, 32'h1234_5678);
        step(1'b1, 32'hFC, 32'hCAFE_F00D);
        step(1'b1, 32'h100, 32'hFFFF_FFFF);
        peek(32'h100, v);
        chk("ram_beyond", v, 32'h0);
        peek(32'h00, v);
        chk("ram_no_alias", v, 32'h1234_5678);
        step(1'b0, 32'hFC, 32'h0);

        // LED register, then asynchronous reset
        step(1'b1, Base, 32'h1A5);
        chk("leds_val", 32'(leds), 32'hA5);
        step(1'b0, Base, 32'h0);
        asyncReset();
        step(1'b0, Base, 32'h0);

        // Timer load/compare/match/W1C
        step(1'b1, Base + 32'h08, 32'd5);
        step(1'b1, Base + 32'h04, 32'h0);
        peek(Base + 32'h04, v);
        chk("cnt_after_clear", v, 32'd0);
        step(1'b0, Base + 32'h04, 32'h0);
        peek(Base + 32'h04, v);
        chk("cnt_next", v, 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, Base + 32'h0C, 32'h0);
        chk("irq_before_match", 32'(irq_timer), 32'h0);
        step(1'b0, Base + 32'h04, 32'h0);
        chk("irq_at_match", 32'(irq_timer), 32'h1);
        for (int i = 0; i < 3; i++) step(1'b0, Base + 32'h0C, 32'h0);
        chk("irq_sticky", 32'(irq_timer), 32'h1);
        step(1'b1, Base + 32'h0C, 32'h1);
        chk("irq_w1c", 32'(irq_timer), 32'h0);
        step(1'b1, Base + 32'h04, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, Base + 32'h04, 32'h0);
        step(1'b1, Base + 32'h0C, 32'h1);
        chk("irq_set_wins", 32'(irq_timer), 32'h1);
        step(1'b1, Base + 32'h0C, 32'h1);
        chk("irq_w1c_again", 32'(irq_timer), 32'h0);

`ifdef DMEM_MMIO_UART_EN
        // UART frame 0x55 with an ignored mid-frame write
        step(1'b1, Base + 32'h10, 32'h55);
        nBusy = 0;
        for (int i = 0; i < FrameCycles; i++) begin
            chk($sformatf("tx_bit%0d", i), 32'(uart_tx), 32'((i / Baud) % 2));
            peek(Base + 32'h14, v);
            if (v == 32'h1) nBusy++;
            if (i == 10) step(1'b1, Base + 32'h10, 32'hFF);
            else step(1'b0, Base + 32'h0C, 32'h0);
        end
        chk("busy_cycles", 32'(nBusy), 32'(FrameCycles));
        peek(Base + 32'h14, v);
        chk("busy_after_frame", v, 32'h0);
        step(1'b0, Base + 32'h10, 32'h0);

        // Reset in the middle of the DATA phase, then a clean frame
        step(1'b1, Base + 32'h10, 32'h55);
        for (int i = 0; i < 9; i++) step(1'b0, Base + 32'h14, 32'h0);
        chk("tx_pre_reset", 32'(uart_tx), 32'h0);
        asyncReset();
        step(1'b1, Base + 32'h10, 32'hA3);
        for (int i = 0; i < FrameCycles + 4; i++) step(1'b0, Base + 32'h0C, 32'h0);
`else
        // No UART: TX window inert, line idles high
        step(1'b1, Base + 32'h10, 32'h55);
        for (int i = 0; i < 20; i++) begin
            peek(Base + 32'h14, v);
            chk("no_uart_busy", v, 32'h0);
            chk("no_uart_tx", 32'(uart_tx), 32'h1);
            step(1'b0, Base + 32'h0C, 32'h0);
        end
`endif

        // Unmapped addresses
        step(1'b1, Base, 32'h3C);
        step(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        step(1'b1, 32'hFFFE_FFFC, 32'hFFFF_FFFF);
        chk("unmapped_leds", 32'(leds), 32'h3C);
        peek(32'h8000_0000, v);
        chk("unmapped_rd", v, 32'h0);
        peek(Base + 32'h1C, v);
        chk("mmio_hole_rd", v, 32'h0);
        step(1'b0, Base + 32'h08, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ad;
            logic [31:0] d;
            logic        w;
            int          sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 4) ad = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
            else if (sel < 8) ad = {Base[31:8], 3'b000, 3'($urandom_range(0, 7)), 2'($urandom)};
            else ad = 32'h4000_0000 | 32'($urandom_range(0, 65535));
            w = $urandom_range(0, 1) == 1;
            d = $urandom;
            if (sel >= 4 && sel < 8 && ad[7:2] == 6'd2) d = 32'($urandom_range(1, 40));
            if (sel >= 4 && sel < 8 && ad[7:2] == 6'd1 && $urandom_range(0, 3) != 0) w = 1'b0;
            step(w, ad, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
Data-memory stage downstream of the pipelined ARM core. It consumes the core's memory-stage outputs (MemWrite, ALUResult, WriteData) and returns ReadData in the same cycle. It holds a word-addressed data RAM and a memory-mapped I/O window. The window contains an LED register, a free-running timer with a compare interrupt, and a UART transmitter.

Parameters:
RAM_WORDS, 64, number of 32-bit RAM words; power of two, at least 4.
MMIO_BASE, 32'hFFFF_0000, base address of the MMIO window; 256-byte aligned.
BAUD_DIV, 16, clk cycles per UART bit; at least 2.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
we  input  1  write enable; driven by the core's MemWrite.
a  input  32  byte address; driven by the core's ALUResult.
wd  input  32  write data; driven by the core's WriteData.
rd  output  32  read data to the core's ReadData; combinational from a and state.
leds  output  8  LED register contents.
irq_timer  output  1  sticky timer-match flag.
uart_tx  output  1  serial TX line; idles high.

Behaviour:
- Decode (a[1:0] ignored; word access only):
  - RAM: a < RAM_WORDS*4. Index is a[log2(RAM_WORDS)+1:2].
  - MMIO: a[31:8] == MMIO_BASE[31:8]. Offset is a[7:0].
  - Anything else is unmapped: reads return 0, writes are dropped.
- Reads: combinational, zero-latency. Writes commit on the rising clk edge when we=1.
- RAM: not reset; contents are X until written. A read in the cycle after a write returns the new data.
- MMIO map (offset, access, function):
  - 0x00, R/W: LED register. wd[7:0] is stored. Reads return {24'b0, leds}.
  - 0x04, R/W: timer count. A write loads 0. Reads return the current count.
  - 0x08, R/W: compare register, 32 bits.
  - 0x0C, R/W1C: status. Bit0 = match flag; writing 1 to bit0 clears it. Bit1 = uart busy, read-only.
  - 0x10, W: UART TX data. Reads return 0.
  - 0x14, R: {31'b0, busy}.
  - Other offsets: read 0, writes ignored.
- Timer:
  - Count increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - A write to 0x04 at edge N makes the count 0 after edge N; it is 1 after edge N+1.
  - Match flag sets on the edge where count == compare and compare != 0.
  - Set and a W1C clear in the same cycle: set wins.
  - irq_timer = match flag.
- UART TX FSM:
  - States: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1, busy=0. A write to 0x10 latches wd[7:0] into the shift register, clears the baud counter and moves to START.
  - A write to 0x10 while busy is ignored; no queueing.
  - START: tx=0 for BAUD_DIV cycles.
  - DATA: 8 bits, LSB first, BAUD_DIV cycles each. A 3-bit counter tracks the bit index.
  - STOP: tx=1 for BAUD_DIV cycles, then IDLE.
  - busy=1 in START/DATA/STOP. A frame is exactly 10*BAUD_DIV cycles from the edge after the write to the return to IDLE.
- Reset values (immediate on reset=0, including mid-frame):
  - leds=0, count=0, compare=0, match flag=0, irq_timer=0.
  - UART state=IDLE, uart_tx=1, shift register=0.
- Simultaneous events:
  - A write and a read to the same address in the same cycle: rd shows the old value.
  - Reset overrides any in-flight write.

Optional Feature:
- Macro: DMEM_MMIO_UART_EN.
- Defined: UART as above.
- Undefined:
  - No UART logic.
  - uart_tx is tied to 1.
  - Offsets 0x10 and 0x14 read 0 and ignore writes.
  - Status bit1 reads 0.

Test Plan:
1. RAM write/read: we=1, a=0x08, wd=0xDEADBEEF, then we=0, a=0x08 -> rd=0xDEADBEEF. Read a=0x0A -> same word. Read a=0x100 (RAM_WORDS=64) -> rd=0.
2. LED register: write 0x1A5 to MMIO_BASE+0x00 -> leds=0xA5 and rd=0x000000A5. Assert reset=0 mid-run -> leds=0 asynchronously.
3. Timer match:
   - Write compare=5, then write count=0 -> count reads 1 on the cycle after the clearing edge.
   - irq_timer rises on the edge where count==5 and stays high.
   - W1C to 0x0C bit0 -> irq low. It re-sets after count wraps back to 5.
4. UART frame (BAUD_DIV=4): write 0x55 to 0x10.
   - tx sequence is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles.
   - busy is high for 40 cycles.
   - A second write mid-frame is ignored and the frame is unchanged.
5. Reset mid-frame: assert reset=0 during the DATA state -> uart_tx=1 and busy=0 immediately. A write after reset release starts a clean frame.
6. Unmapped/simultaneous:
   - Write to 0x8000_0000 -> no state changes.
   - Match and W1C in the same cycle -> flag remains 1.
   - Build without DMEM_MMIO_UART_EN -> uart_tx constantly 1 and 0x14 reads 0.
